// File: rtl/oz_muldiv_unit.sv
// Iterative RV M-extension execute unit: radix-2 shift-add multiply and
// restoring divide over a shared accumulator, with valid/ready on both sides.
module oz_muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [2:0]            InOp,
  input  logic [DATA_WIDTH-1:0] InSrc1,
  input  logic [DATA_WIDTH-1:0] InSrc2,
  input  logic [TAG_WIDTH-1:0]  InTag,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutResult,
  output logic [TAG_WIDTH-1:0]  OutTag,
  output logic                  OutDivZero,
  output logic                  Busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                neg_q;
  logic [W:0]          b_q;
  logic [2*W:0]        acc;
  logic [W-1:0]        res_q;
  logic                dz_q;

  // request decode
  logic          is_mul, s1_signed, s2_signed, neg1, neg2;
  logic [W:0]    ext1, ext2, mag1, mag2;
  logic          div_zero, overflow, special, res_neg, accept;
  logic [W-1:0]  special_res;

  always_comb begin
    is_mul    = !InOp[2];
    s1_signed = is_mul ? (InOp[1:0] != 2'b11) : !InOp[0];
    s2_signed = is_mul ? !InOp[1] : !InOp[0];
    neg1      = s1_signed & InSrc1[W-1];
    neg2      = s2_signed & InSrc2[W-1];
    ext1      = {neg1, InSrc1};
    ext2      = {neg2, InSrc2};
    mag1      = neg1 ? -ext1 : ext1;
    mag2      = neg2 ? -ext2 : ext2;
    div_zero  = InOp[2] & (InSrc2 == '0);
    overflow  = InOp[2] & !InOp[0] & (InSrc1 == {1'b1, {(W-1){1'b0}}}) & (&InSrc2);
    special   = div_zero | overflow;
    res_neg   = (InOp[2] & InOp[1]) ? neg1 : (neg1 ^ neg2);
    if (div_zero)
      special_res = InOp[1] ? InSrc1 : '1;
    else
      special_res = InOp[1] ? '0 : InSrc1;
    accept    = InValid & InReady;
  end

  // one radix-2 step; acc = {carry/rem-msb, hi, lo}
  logic [W:0]     sum, shifted;
  logic [W+1:0]   diff;
  logic [2*W:0]   step_acc;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo, rem, quo_s, rem_s, fix_res;

  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? b_q : '0);
    shifted  = {acc[2*W-1:W], acc[W-1]};
    diff     = {1'b0, shifted} - {1'b0, b_q};
    if (op_q[2])
      step_acc = diff[W+1] ? {shifted, acc[W-2:0], 1'b0}
                           : {diff[W:0], acc[W-2:0], 1'b1};
    else
      step_acc = {1'b0, sum, acc[W-1:1]};
    prod     = step_acc[2*W-1:0];
    prod_s   = neg_q ? -prod : prod;
    quo      = step_acc[W-1:0];
    rem      = step_acc[2*W-1:W];
    quo_s    = neg_q ? -quo : quo;
    rem_s    = neg_q ? -rem : rem;
    if (op_q[2])
      fix_res = op_q[1] ? rem_s : quo_s;
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (OutReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Flush) state_nxt = IDLE;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      tag_q <= '0;
      neg_q <= 1'b0;
      b_q   <= '0;
      acc   <= '0;
      res_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= InOp;
      tag_q <= InTag;
      neg_q <= res_neg;
      b_q   <= mag2;
      acc   <= {{W{1'b0}}, mag1};
      cnt   <= CW'(W - 1);
      dz_q  <= div_zero;
      if (special) res_q <= special_res;
    end else if (state == CALC) begin
      acc <= step_acc;
      cnt <= cnt - CW'(1);
      if (cnt == '0) res_q <= fix_res;
    end
  end

  assign InReady    = (state == IDLE) & !Flush;
  assign Busy       = (state != IDLE);
  assign OutValid   = (state == DONE);
  assign OutResult  = res_q;
  assign OutTag     = tag_q;
  assign OutDivZero = dz_q;

endmodule

// File: tb/tb_oz_muldiv_unit.sv
// Directed bench for oz_muldiv_unit: 32-bit instance for the op set and
// handshake/flush/reset behaviour, 8-bit instance for the narrow build.
module tb_oz_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] src1, src2, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        out_div_zero, busy;

  logic        s8_flush, s8_valid, s8_in_ready, s8_out_valid, s8_out_ready;
  logic [2:0]  s8_op;
  logic [7:0]  s8_src1, s8_src2, s8_result;
  logic [4:0]  s8_tag, s8_out_tag;
  logic        s8_dz, s8_busy;

  oz_muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready),
    .InOp(in_op), .InSrc1(src1), .InSrc2(src2), .InTag(in_tag),
    .OutValid(out_valid), .OutReady(out_ready), .OutResult(out_result),
    .OutTag(out_tag), .OutDivZero(out_div_zero), .Busy(busy)
  );

  oz_muldiv_unit #(.DATA_WIDTH(8), .TAG_WIDTH(5)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .Flush(s8_flush), .InValid(s8_valid), .InReady(s8_in_ready),
    .InOp(s8_op), .InSrc1(s8_src1), .InSrc2(s8_src2), .InTag(s8_tag),
    .OutValid(s8_out_valid), .OutReady(s8_out_ready), .OutResult(s8_result),
    .OutTag(s8_out_tag), .OutDivZero(s8_dz), .Busy(s8_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_op = op; src1 = a; src2 = b; in_tag = t; in_valid = 1'b1;
    check("in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int lat;
    issue(op, a, b, t);
    wait_valid(lat);
    check({name, ":lat"}, 64'(lat), 64'(exp_lat));
    check({name, ":res"}, {32'd0, out_result}, {32'd0, exp_res});
    check({name, ":tag"}, {59'd0, out_tag}, {59'd0, t});
    check({name, ":dz"}, {63'd0, out_div_zero}, {63'd0, exp_dz});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ":drop"}, {63'd0, out_valid}, 64'd0);
    check({name, ":rdy"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    logic saw;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; src1 = '0; src2 = '0; in_tag = '0;
    s8_flush = 1'b0; s8_valid = 1'b0; s8_out_ready = 1'b0;
    s8_op = '0; s8_src1 = '0; s8_src2 = '0; s8_tag = '0;
    #12;
    check("rst:valid", {63'd0, out_valid}, 64'd0);
    check("rst:res", {32'd0, out_result}, 64'd0);
    check("rst:tag", {59'd0, out_tag}, 64'd0);
    check("rst:dz", {63'd0, out_div_zero}, 64'd0);
    check("rst:busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle:rdy", {63'd0, in_ready}, 64'd1);

    run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'h2, 5'd1, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'h2, 5'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'h2, 5'd3, 32'h0000_0001, 1'b0, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h2, 5'd4, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h2, 5'd6, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("divu",   3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0, 33);
    run_op("remu",   3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 1'b0, 33);
    run_op("divu0",  3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("rem0",   3'b110, 32'd5, 32'd0, 5'd10, 32'd5, 1'b1, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1'b0, 1);

    // backpressure in DONE
    issue(3'b101, 32'd100, 32'd7, 5'd13);
    check("bp:busy", {63'd0, busy}, 64'd1);
    wait_valid(lat);
    check("bp:lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp:valid", {63'd0, out_valid}, 64'd1);
      check("bp:res", {32'd0, out_result}, 64'd14);
      check("bp:tag", {59'd0, out_tag}, 64'd13);
      check("bp:rdy", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp:drop", {63'd0, out_valid}, 64'd0);
    check("bp:rdy_after", {63'd0, in_ready}, 64'd1);

    // flush mid-CALC
    issue(3'b000, 32'd5, 32'd6, 5'd14);
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush:valid", {63'd0, out_valid}, 64'd0);
    check("flush:busy", {63'd0, busy}, 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    check("flush:novalid", {63'd0, saw}, 64'd0);
    run_op("mul34", 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 1'b0, 33);

    // flush together with a request
    in_op = 3'b101; src1 = 32'd5; src2 = 32'd0; in_tag = 5'd16;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flushreq:rdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flushreq:busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("flushreq:valid", {63'd0, out_valid}, 64'd0);

    // asynchronous reset mid-CALC
    issue(3'b001, 32'hFFFF_FFFF, 32'h2, 5'd17);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst:valid", {63'd0, out_valid}, 64'd0);
    check("arst:busy", {63'd0, busy}, 64'd0);
    check("arst:tag", {59'd0, out_tag}, 64'd0);
    check("arst:res", {32'd0, out_result}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst:rdy", {63'd0, in_ready}, 64'd1);

    // 8-bit build: MULH 0x80*0x80
    s8_op = 3'b001; s8_src1 = 8'h80; s8_src2 = 8'h80; s8_tag = 5'd21; s8_valid = 1'b1;
    check("w8:rdy", {63'd0, s8_in_ready}, 64'd1);
    @(posedge clk); #1;
    s8_valid = 1'b0;
    lat = 1;
    while (s8_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8:lat", 64'(lat), 64'd9);
    check("w8:res", {56'd0, s8_result}, 64'h40);
    check("w8:tag", {59'd0, s8_out_tag}, 64'd21);
    s8_out_ready = 1'b1;
    @(posedge clk); #1;
    s8_out_ready = 1'b0;
    check("w8:drop", {63'd0, s8_out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oz_muldiv_unit.md
Name: oz_muldiv_unit

Overview:
Iterative, parametrised RV M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It is the multi-cycle successor to the single-cycle core's combinational ALU datapath. It sits beside the ALU and accepts operands, a 3-bit funct3 op code and a destination tag through a valid/ready handshake. It returns one result per accepted op through an output valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; must be ≥4 and even.
TAG_WIDTH, 5, width of the opaque tag (rd index) carried with each op.

Ports:
Clk  input  1  clock, all state on rising edge
Rst_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous kill of any in-flight or pending op
InValid  input  1  request valid
InReady  output  1  unit can accept a request
InOp  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
InSrc1  input  DATA_WIDTH  rs1 value
InSrc2  input  DATA_WIDTH  rs2 value
InTag  input  TAG_WIDTH  tag returned with the result
OutValid  output  1  result valid
OutReady  input  1  consumer accepts the result
OutResult  output  DATA_WIDTH  result
OutTag  output  TAG_WIDTH  tag of the result
OutDivZero  output  1  result came from a divide/remainder with rs2==0
Busy  output  1  FSM not IDLE

Behaviour:
- Reset (Rst_n low, async):
  - FSM = IDLE.
  - OutValid=0, OutResult=0, OutTag=0, OutDivZero=0, Busy=0.
  - Counter and operand registers cleared.
- FSM states: IDLE, CALC, DONE.
  - InReady = (state==IDLE) and not Flush.
  - Busy = (state!=IDLE).
- IDLE:
  - Accept when InValid & InReady. The unit latches op, operands (sign-converted to magnitudes) and tag, and records the result sign.
  - Normal op: go to CALC, counter = DATA_WIDTH-1.
  - Special divide case: go directly to DONE with the result preloaded.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add over a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each step. When the counter==0 step completes, apply the sign fix-up and go to DONE.
- Normal latency: OutValid rises exactly DATA_WIDTH+1 cycles after the accept edge.
- DONE:
  - OutValid=1; OutResult, OutTag and OutDivZero are held stable until OutValid & OutReady.
  - On handshake go to IDLE. A new request can be accepted in the cycle after that (no same-cycle back-to-back).
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Magnitudes are formed in DATA_WIDTH+1 bits so the most-negative value is handled.
- Result selection:
  - MUL: low DATA_WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high DATA_WIDTH bits of the signed-corrected 2W product.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Special cases, latency 1 (OutValid the cycle after accept):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1; OutDivZero=1.
  - Signed overflow (DIV/REM with rs1=most-negative, rs2=-1): DIV = most-negative, REM = 0, OutDivZero=0.
  - Multiplies have no fast path.
- Flush:
  - In any state, next cycle: FSM = IDLE, OutValid=0; the result is discarded.
  - Flush with InValid in the same cycle: the request is not accepted.
  - Flush together with a DONE handshake: the handshake completes and the unit still ends in IDLE.
- Reset mid-CALC: aborts immediately, no output produced.
- OutValid must never drop without a handshake or Flush.
- Inputs are ignored outside IDLE.

Test Plan:
- MUL/MULH/MULHU/MULHSU, rs1=0xFFFF_FFFF, rs2=0x0000_0002 -> results 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0001, 0xFFFF_FFFF. OutValid exactly 33 cycles after accept; tag echoed.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2 -> 0xFFFF_FFFD. REM same operands -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFF_FFFF with OutDivZero=1. REM 5/0 -> 5. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, REM -> 0. All with OutValid one cycle after accept.
- Backpressure: hold OutReady=0 for 10 cycles in DONE -> OutValid, OutResult and OutTag stable and InReady=0. Release -> handshake, then InReady=1 next cycle.
- Flush at CALC cycle 5 with a pending op -> no OutValid. Next op (MUL 3*4) -> 12 after 33 cycles. Flush with InValid in the same cycle -> request dropped.
- Rst_n pulsed low asynchronously mid-CALC -> all outputs 0 immediately. DATA_WIDTH=8 build: MULH 0x80*0x80 -> 0x40, latency 9.
